// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 3x3 convolution window generator.
package conv_pkg;

  localparam int KERNEL_DIM     = 3;
  localparam int KERNEL_TAPS    = 9;
  localparam int DEFAULT_DATA_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } conv_state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage: combinational read and synchronous write at the same address.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are never reset; rows are always rewritten before a window uses them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Builds 3x3 windows from a raster pixel stream using two line buffers.
// Optional macro CONV_WINDOW_COUNT_EN adds a per-frame window counter output.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] subimage0,
  output logic [DATA_W-1:0] subimage1,
  output logic [DATA_W-1:0] subimage2,
  output logic [DATA_W-1:0] subimage3,
  output logic [DATA_W-1:0] subimage4,
  output logic [DATA_W-1:0] subimage5,
  output logic [DATA_W-1:0] subimage6,
  output logic [DATA_W-1:0] subimage7,
  output logic [DATA_W-1:0] subimage8,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              frame_done
`ifdef CONV_WINDOW_COUNT_EN
  ,
  output logic [15:0]       win_count
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  conv_state_e       state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] win_q [KERNEL_TAPS];
  logic [DATA_W-1:0] win_d [KERNEL_TAPS];
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              accept, handoff;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  // Both sides use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; a producer holds valid and data stable until that edge.
  assign pix_ready = en & (state_q != DONE) & (~win_valid_q | win_ready);
  assign accept    = pix_valid & pix_ready;
  assign handoff   = win_valid_q & win_ready;

  // lb1 holds the previous row, lb0 the row before it; the old lb1 entry cascades into lb0.
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (pix_in),
    .rdata (lb1_rd)
  );

  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    frame_done_d = 1'b0;
    win_valid_d  = win_valid_q & ~handoff;

    if (accept) begin
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM - 1; c++) begin
          win_d[r*KERNEL_DIM + c] = win_q[r*KERNEL_DIM + c + 1];
        end
      end
      win_d[KERNEL_DIM-1]   = lb0_rd;
      win_d[2*KERNEL_DIM-1] = lb1_rd;
      win_d[KERNEL_TAPS-1]  = pix_in;

      // Requiring col>=2 keeps stale columns from the previous row out of any window.
      if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
        win_valid_d = 1'b1;
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case (state_q)
      IDLE: if (accept) state_d = FILL;
      FILL: if (accept && row_q == ROW_TWO && col_q == COL_ONE) state_d = RUN;
      RUN:  if (accept && row_q == ROW_LAST && col_q == COL_LAST) state_d = DONE;
      DONE: begin
        if (handoff) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          col_d        = '0;
          row_d        = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

`ifdef CONV_WINDOW_COUNT_EN
  logic [15:0] win_count_q, win_count_d;

  always_comb begin
    win_count_d = win_count_q;
    if (frame_done_q) begin
      win_count_d = '0;
    end else if (handoff) begin
      win_count_d = win_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_count_q <= '0;
    end else begin
      win_count_q <= win_count_d;
    end
  end

  assign win_count = win_count_q;
`endif

  assign subimage0  = win_q[0];
  assign subimage1  = win_q[1];
  assign subimage2  = win_q[2];
  assign subimage3  = win_q[3];
  assign subimage4  = win_q[4];
  assign subimage5  = win_q[5];
  assign subimage6  = win_q[6];
  assign subimage7  = win_q[7];
  assign subimage8  = win_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule
